// File: rtl/mwadd_pkg.sv
// Shared types and helpers for the sequential multiword adder.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mwadd_state_t;

  // Slice counter width; WORDS=1 still needs a 1-bit counter.
  function automatic int cnt_w(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/bitnadder.sv
// N-bit ripple-carry slice adder: s = x + y + c_i, c_o = carry out of bit N-1.
module bitnadder #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_i,
  output logic [N-1:0] s,
  output logic         c_o
);

  logic [N:0] w_c;

  assign w_c[0] = c_i;

  // One full adder per bit, carry rippling upward.
  for (genvar g = 0; g < N; g++) begin : g_fa
    assign s[g]     = x[g] ^ y[g] ^ w_c[g];
    assign w_c[g+1] = (x[g] & y[g]) | (w_c[g] & (x[g] ^ y[g]));
  end

  assign c_o = w_c[N];

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential wide adder: W-bit a+b+c_in computed one N-bit slice per cycle
// through a single bitnadder, carry held in a register between slices.
// Optional feature: define MWADD_OVF_EN to add the registered signed
// overflow output ovf.
module multiword_adder_seq
  import mwadd_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
`ifdef MWADD_OVF_EN
  output logic         ovf,
`endif
  output logic         c_out
);

  localparam int CW = cnt_w(WORDS);

  mwadd_state_t r_state, w_state_nxt;

  logic [W-1:0]   r_a, r_b, r_sum;
  logic           r_carry, r_cout;
  logic [CW-1:0]  r_cnt;

  logic [N-1:0]   w_s;
  logic           w_co;
  logic           w_last;
  logic           w_accept;
  logic [W+N-1:0] w_sum_cat;

  bitnadder #(.N(N)) u_slice (
    .x   (r_a[N-1:0]),
    .y   (r_b[N-1:0]),
    .c_i (r_carry),
    .s   (w_s),
    .c_o (w_co)
  );

  assign w_last    = (r_cnt == CW'(WORDS - 1));
  assign w_accept  = in_valid && (r_state == IDLE);
  // Slice result enters at the MSB end; after WORDS shifts slice 0 sits at the bottom.
  assign w_sum_cat = {w_s, r_sum};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand shift regs, slice counter and inter-slice carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> N;
      r_b     <= r_b >> N;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result registers; they move only while RUN so DONE holds them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum <= w_sum_cat[W+N-1:N];
      if (w_last) r_cout <= w_co;
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

`ifdef MWADD_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  // Carry into bit W-1 recovered from the top slice's MSB operands and sum.
  assign w_c_msb = r_a[N-1] ^ r_b[N-1] ^ w_s[N-1];

  // Signed overflow, updated alongside c_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c_msb ^ w_co;
  end

  assign ovf = r_ovf;
`endif

endmodule
